// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter.
// Holds the operation encodings, the FSM state encodings and the default
// per-cycle shift distance used by shift_seq and shift_step.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    localparam int unsigned DEFAULT_STEP = 4;

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-step shifter, shifting by 0..STEP bits.
// Configuration macro: SHIFT_SEQ_ROTATE_EN -- when defined, OP_ROTR rotates
// right; when undefined, OP_ROTR behaves as SRL and no rotate logic exists.
// Ports:
//   data   in  32          operand
//   op     in  op_e        shift operation
//   sign   in  1           fill bit used by SRA
//   amount in  clog2(STEP)+1  shift distance, 0..STEP
//   result out 32          shifted operand
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned STEP = DEFAULT_STEP
) (
    input  logic [31:0]          data,
    input  op_e                  op,
    input  logic                 sign,
    input  logic [$clog2(STEP):0] amount,
    output logic [31:0]          result
);

    // Ones in the bit positions vacated by a right shift.
    logic [31:0] vacated;

    always_comb begin
        vacated = ~(32'hFFFF_FFFF >> amount);
        case (op)
            OP_SLL:  result = data << amount;
            OP_SRL:  result = data >> amount;
            OP_SRA:  result = (data >> amount) | ({32{sign}} & vacated);
`ifdef SHIFT_SEQ_ROTATE_EN
            // A left shift by 32 yields zero, so amount 0 needs no special case.
            OP_ROTR: result = (data >> amount) | (data << (6'd32 - 6'(amount)));
`endif
            default: result = data >> amount;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle barrel shifter with valid/ready handshakes.
// Shifts by at most STEP bits per cycle until the requested amount is done.
// Configuration macro: SHIFT_SEQ_ROTATE_EN -- enables rotate-right for op 11
// (otherwise op 11 executes as SRL).
// Ports:
//   clk        in  1   clock, rising edge
//   rst        in  1   synchronous active-high reset
//   flush      in  1   abandon in-flight operation
//   req_valid  in  1   request present
//   req_ready  out 1   high only in IDLE
//   req_op     in  2   00 SLL, 01 SRL, 10 SRA, 11 ROTR
//   req_data   in  32  operand
//   req_shamt  in  5   shift amount 0..31
//   rsp_valid  out 1   result present
//   rsp_ready  in  1   consumer accepts result
//   rsp_data   out 32  result, zero when rsp_valid is low
//   busy       out 1   high in any state other than IDLE
module shift_seq
    import shift_pkg::*;
#(
    parameter int unsigned STEP = DEFAULT_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_data,
    input  logic [4:0]  req_shamt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy
);

    localparam int unsigned AW = $clog2(STEP) + 1;

    state_e      state;
    op_e         op_q;
    logic [31:0] data_q;
    logic        sign_q;
    logic [4:0]  remaining;

    logic          last;
    logic [AW-1:0] k;
    logic [31:0]   step_out;

    // Final step when what is left fits within one STEP.
    always_comb begin
        last = ({1'b0, remaining} <= 6'(STEP));
        k    = last ? AW'(remaining) : AW'(STEP);
    end

    shift_step #(
        .STEP (STEP)
    ) u_step (
        .data   (data_q),
        .op     (op_q),
        .sign   (sign_q),
        .amount (k),
        .result (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= OP_SLL;
            data_q    <= '0;
            sign_q    <= 1'b0;
            remaining <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            remaining <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        data_q    <= req_data;
                        op_q      <= op_e'(req_op);
                        sign_q    <= req_data[31];
                        remaining <= req_shamt;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_shamt == '0) begin
                            state     <= S_DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= req_data;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    data_q    <= step_out;
                    remaining <= remaining - 5'(k);
                    if (last) begin
                        state     <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= step_out;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        rsp_valid <= 1'b0;
                        rsp_data  <= '0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_data  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq (STEP = 4).
// Honours SHIFT_SEQ_ROTATE_EN for the expected behaviour of op 11.
module tb_shift_seq;

    localparam int unsigned STEP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_data = '0;
    logic [4:0]  req_shamt = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        busy;

    shift_seq #(
        .STEP (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_shamt (req_shamt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    // Reference: whole shift in one go, straight from the operation definitions.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int sh);
        logic signed [31:0] sd;
        sd = $signed(d);
        case (op)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10:   return sd >>> sh;
`ifdef SHIFT_SEQ_ROTATE_EN
            default: return (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
`else
            default: return d >> sh;
`endif
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic        started = 1'b0;
    logic        inflight = 1'b0;
    logic        shown = 1'b0;
    int          accept_cyc = 0;
    logic [31:0] cur_data = '0;

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            checks++;
            if (busy !== inflight) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, inflight);
            end
            checks++;
            if (req_ready !== !inflight) begin
                errors++;
                $display("FAIL req_ready cyc=%0d got=%b want=%b", cyc, req_ready, !inflight);
            end
            if (!inflight) begin
                checks++;
                if (rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rsp_valid_idle cyc=%0d got=%b want=0", cyc, rsp_valid);
                end
                checks++;
                if (rsp_data !== 32'h0) begin
                    errors++;
                    $display("FAIL rsp_data_idle cyc=%0d got=%h want=00000000", cyc, rsp_data);
                end
            end else if (rsp_valid === 1'b1) begin
                if (!shown) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected cyc=%0d got=%h want=none", cyc, rsp_data);
                    end else begin
                        e = exp_q.pop_front();
                        cur_data = e.data;
                        if (rsp_data !== e.data) begin
                            errors++;
                            $display("FAIL rsp_data cyc=%0d got=%h want=%h", cyc, rsp_data, e.data);
                        end
                        checks++;
                        if (cyc - accept_cyc != e.lat) begin
                            errors++;
                            $display("FAIL latency cyc=%0d got=%0d want=%0d", cyc, cyc - accept_cyc, e.lat);
                        end
                    end
                    shown = 1'b1;
                end else begin
                    checks++;
                    if (rsp_data !== cur_data) begin
                        errors++;
                        $display("FAIL rsp_stable cyc=%0d got=%h want=%h", cyc, rsp_data, cur_data);
                    end
                end
            end else begin
                checks++;
                if (shown || rsp_data !== 32'h0) begin
                    errors++;
                    $display("FAIL rsp_pending cyc=%0d got_valid=%b got_data=%h want_valid=%b want_data=00000000",
                             cyc, rsp_valid, rsp_data, shown);
                end
            end
        end
        // Predict the effect of the coming rising edge.
        if (rst) begin
            started  = 1'b1;
            inflight = 1'b0;
            shown    = 1'b0;
        end else if (started) begin
            if (flush) begin
                inflight = 1'b0;
                shown    = 1'b0;
            end else if (!inflight && req_valid) begin
                inflight   = 1'b1;
                accept_cyc = cyc;
            end else if (inflight && rsp_valid && rsp_ready) begin
                inflight = 1'b0;
                shown    = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // abort_kind: 0 none, 1 flush, 2 rst; abort_at: cycle after accept (1 = first SHIFT cycle)
    task automatic issue(input logic [1:0] op, input logic [31:0] d, input int sh,
                         input int rdelay, input int abort_kind, input int abort_at);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got=%b want=1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_shamt = 5'(sh);
        if (abort_kind == 0) begin
            exp_q.push_back('{ref_shift(op, d, sh), (sh + int'(STEP) - 1) / int'(STEP) + 1});
            if (rdelay == 0) rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_data  = $urandom;
        req_shamt = 5'($urandom);
        if (abort_kind != 0) begin
            repeat (abort_at - 1) begin
                @(posedge clk); #1;
            end
            if (abort_kind == 1) flush = 1'b1;
            else rst = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            rst   = 1'b0;
        end else begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 64) begin
                req_valid = ($urandom_range(0, 3) == 0);
                @(posedge clk); #1;
                n++;
            end
            req_valid = 1'b0;
            if (rsp_valid !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL rsp_timeout got=%b want=1", rsp_valid);
            end else begin
                repeat (rdelay) begin
                    @(posedge clk); #1;
                end
                rsp_ready = 1'b1;
                @(posedge clk); #1;
            end
            rsp_ready = 1'b0;
        end
    endtask

    task automatic flush_idle();
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_data  = 32'h1;
        req_shamt = 5'd3;
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sh;
        int ab;
        int at;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        issue(2'b00, 32'h0000_0001, 31, 0, 0, 0);
        issue(2'b10, 32'h8000_0000, 4, 1, 0, 0);
        issue(2'b01, 32'h8000_0000, 4, 0, 0, 0);
        issue(2'b01, 32'h1234_5678, 0, 5, 0, 0);
        issue(2'b00, 32'h0000_0001, 20, 0, 1, 3);
        issue(2'b00, 32'h0000_0001, 1, 0, 0, 0);
        issue(2'b10, 32'hF000_000F, 20, 0, 2, 2);
        issue(2'b00, 32'h0000_0001, 3, 2, 0, 0);
        issue(2'b11, 32'h0000_00F1, 4, 0, 0, 0);
        issue(2'b11, 32'h8000_0001, 17, 1, 0, 0);
        issue(2'b10, 32'h7FFF_FFFF, 16, 0, 0, 0);
        flush_idle();
        issue(2'b01, 32'hDEAD_BEEF, 8, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            sh = int'($urandom_range(0, 31));
            ab = 0;
            at = 0;
            if (sh >= int'(STEP) && $urandom_range(0, 9) == 0) begin
                ab = int'($urandom_range(1, 2));
                at = int'($urandom_range(1, (sh + int'(STEP) - 1) / int'(STEP)));
            end
            issue(2'($urandom), $urandom, sh, int'($urandom_range(0, 3)), ab, at);
            if ($urandom_range(0, 15) == 0) flush_idle();
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
